sdc_port_sched: RTL and testbench
=================================

# sdc_port_sched

Two-port request scheduler placed in front of the SDRAM/DDR data path. It arbitrates read and write requests from two host ports and drives the data path's `sdc_read`/`sdc_write` enable windows, `req_len` and `rdAdr` strobes. It also returns a per-port grant and a completion pulse that accounts for CAS latency and the data-path pipeline. It owns direction turnaround, so the data path never sees overlapping read and write windows.

## Interface
- `TURN_CYC`, 2: idle cycles inserted after every write burst window.
- `clk` in 1: single system clock. All logic runs on the rising edge.
- `rst2` in 1: reset, synchronous, active-high.
- `req0` / `req1` in 1: port request, held high until that port's `done` pulse.
- `we0` / `we1` in 1: direction, 1 = write, 0 = read. Sampled only in GRANT.
- `len0` / `len1` in 2: number of bursts minus 1 (1–4 bursts). Sampled only in GRANT.
- `sdc_sel` in 1: 1 = SDR, 0 = DDR. Must be static while `busy` is high.
- `cfg_bl` in 2: beats per burst, 00 = 1, 01 = 2, 10 = 4, 11 = 8.
- `cas_lat_max` in 2: CAS latency in cycles, 01 = 2, 10 = 3.
- `gnt0` / `gnt1` out 1: port owns the data path.
- `done0` / `done1` out 1: one-cycle completion pulse.
- `sdc_read` / `sdc_write` out 1: burst window enables to the data path.
- `req_len` out 2: latched length of the current request.
- `rdAdr` out 1: pulses on the first cycle of each read burst.
- `busy` out 1: high in any state except IDLE.

## Operation
- States are IDLE, GRANT, XFER, DRAIN and TURN.
- **IDLE**
  - Any request moves the FSM to GRANT and selects a port.
  - Round-robin: when both ports request, the port not served last wins. After reset, port 0 wins.
- **GRANT** (1 cycle)
  - Asserts `gntX`.
  - Latches `weX`, `lenX` into `req_len`, and the cycle count N = (len+1)·B.
  - Burst cycles B: SDR uses B = beats; DDR uses B = max(1, beats/2).
- **XFER** (N cycles)
  - `sdc_write` or `sdc_read` is held high for all N cycles.
  - For reads, `rdAdr` pulses on XFER cycles 0, B, 2B, …
  - When the count expires:
    - a write pulses `doneX` for one cycle, then goes to TURN;
    - a read goes to DRAIN.
- **DRAIN** (`cas_lat_max`+2 cycles)
  - `doneX` pulses on the last DRAIN cycle, then the FSM goes to IDLE.
- **TURN** (`TURN_CYC` cycles), then IDLE. If `TURN_CYC` = 0, the FSM goes directly to IDLE.
- **Grant and request rules**
  - `gntX` stays high from GRANT through the cycle of `doneX`, inclusive.
  - If `reqX` drops mid-transfer, the transfer still completes and `doneX` still pulses.
  - `reqX` still high in the cycle after `doneX` is treated as a new request.
- `sdc_read` and `sdc_write` are never high together. Both are low in GRANT, DRAIN, TURN and IDLE.
- All outputs are registered.

## Timing
- **Reset:** all outputs 0, state IDLE, round-robin pointer favours port 0. `req_len` resets to 00.
- **Reset mid-operation:** all outputs are 0 on the cycle after `rst2` is sampled high. No `done` pulse is issued for the aborted request.
- **Latency**, with `req` first seen at cycle 0:
  - GRANT and `gnt` at cycle 1.
  - Window occupies cycles 2 … N+1.
  - Write `done` at cycle N+2.
  - Read `done` at cycle N+3+`cas_lat_max`.
- **Minimum request-to-request spacing** (next `gnt` after `done`):
  - after a read: 2 cycles (IDLE, then GRANT);
  - after a write: `TURN_CYC`+2 cycles.
- Counters are 6 bits wide (maximum N = 32), with no wrap-around.

## Configuration
- `SDC_SCHED_PRIO_EN`
  - Defined: fixed priority, port 0 always wins simultaneous requests. The round-robin pointer is removed.
  - Undefined: round-robin as described above.

## Test plan
- **SDR single write:** `sdc_sel`=1, `cfg_bl`=10, `len0`=0, `we0`=1, `req0` at cycle 0 → `gnt0` at 1, `sdc_write` high cycles 2–5, `done0` at 6, `busy` low at 9.
- **DDR read, two bursts:** `sdc_sel`=0, `cfg_bl`=11, `len1`=1, `cas_lat_max`=10 → `sdc_read` high cycles 2–9, `rdAdr` at 2 and 6, `done1` at 14, `req_len`=01.
- **Simultaneous requests after reset:** `req0` and `req1` both held → port 0 served first, then port 1, then port 0 again, with no overlap of `gnt0`/`gnt1`.
- **`SDC_SCHED_PRIO_EN` defined:** `req1` held while `req0` is re-asserted after each `done0` → port 1 is never granted.
- **Reset during XFER:** `rst2` high at XFER cycle 2 → `sdc_read`/`sdc_write`, `gnt` and `busy` are 0 on the next cycle, no `done`. After release with both ports requesting, port 0 is granted.
- **DDR single beat:** `sdc_sel`=0, `cfg_bl`=00, `len`=0 → `sdc_read` high 1 cycle with `rdAdr` on the same cycle, `done` at 4+`cas_lat_max`.

Source files
------------

// File: rtl/sdc_port_sched.sv
// rtl/sdc_port_sched.sv - two-port SDRAM/DDR request scheduler; `SDC_SCHED_PRIO_EN selects fixed priority
module sdc_port_sched #(
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst2,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] len0,
  input  logic [1:0] len1,
  input  logic       sdc_sel,
  input  logic [1:0] cfg_bl,
  input  logic [1:0] cas_lat_max,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       sdc_read,
  output logic       sdc_write,
  output logic [1:0] req_len,
  output logic       rdAdr,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  localparam logic [5:0] TURN_LD = 6'(TURN_CYC);

  state_t     state_q, state_d;
  logic       port_q, port_d;
  logic       we_q, we_d;
  logic [5:0] last_q, last_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] mask_q, mask_d;
  logic [1:0] req_len_q, req_len_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       sdc_read_q, sdc_read_d;
  logic       sdc_write_q, sdc_write_d;
  logic       rd_adr_q, rd_adr_d;
  logic       busy_q, busy_d;
  logic       done_d;
  logic       pick;
  logic [1:0] len_sel;
  logic       we_sel;
  logic [1:0] shift;
  logic [2:0] bmask;
  logic [5:0] nbursts;
`ifndef SDC_SCHED_PRIO_EN
  logic       rr_q, rr_d;
`endif

  // Port chosen when leaving IDLE: fixed priority or the port not served last
  always_comb begin
`ifdef SDC_SCHED_PRIO_EN
    pick = ~req0;
`else
    pick = (req0 && req1) ? ~rr_q : req1;
`endif
  end

  // Burst geometry of the port being granted: log2(B) and the beat-index mask
  always_comb begin
    len_sel = port_q ? len1 : len0;
    we_sel  = port_q ? we1 : we0;
    if (sdc_sel) begin
      shift = cfg_bl;
    end else if (cfg_bl == 2'd0) begin
      shift = 2'd0;
    end else begin
      shift = cfg_bl - 2'd1;
    end
    case (shift)
      2'd0:    bmask = 3'd0;
      2'd1:    bmask = 3'd1;
      2'd2:    bmask = 3'd3;
      default: bmask = 3'd7;
    endcase
    nbursts = {4'd0, len_sel} + 6'd1;
  end

  // Next-state logic; cnt_q is the beat index in XFER and a down-counter in DRAIN/TURN
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    last_d    = last_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    req_len_d = req_len_q;
    done_d    = 1'b0;
`ifndef SDC_SCHED_PRIO_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_GRANT;
          port_d  = pick;
`ifndef SDC_SCHED_PRIO_EN
          rr_d    = pick;
`endif
        end
      end
      S_GRANT: begin
        we_d      = we_sel;
        req_len_d = len_sel;
        last_d    = (nbursts << shift) - 6'd1;
        mask_d    = bmask;
        cnt_d     = 6'd0;
        state_d   = S_XFER;
      end
      S_XFER: begin
        if (cnt_q == last_q) begin
          if (we_q) begin
            // The write completion cycle is the first TURN cycle
            state_d = S_TURN;
            cnt_d   = TURN_LD;
            done_d  = 1'b1;
          end else begin
            // CAS latency is encoding+1 cycles; DRAIN lasts CAS+2 cycles
            state_d = S_DRAIN;
            cnt_d   = {4'd0, cas_lat_max} + 6'd2;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 6'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            done_d = 1'b1;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == 6'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, so every output comes straight from a flop
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    sdc_read_d  = 1'b0;
    sdc_write_d = 1'b0;
    rd_adr_d    = 1'b0;
    busy_d      = (state_d != S_IDLE);
    if ((state_d inside {S_GRANT, S_XFER, S_DRAIN}) || done_d) begin
      gnt0_d = ~port_d;
      gnt1_d = port_d;
    end
    done0_d = done_d & ~port_d;
    done1_d = done_d & port_d;
    if (state_d == S_XFER) begin
      sdc_write_d = we_d;
      sdc_read_d  = ~we_d;
      rd_adr_d    = ~we_d && ((cnt_d[2:0] & mask_d) == 3'd0);
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst2) begin
      state_q     <= S_IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 6'd0;
      mask_q      <= 3'd0;
      cnt_q       <= 6'd0;
      req_len_q   <= 2'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      sdc_read_q  <= 1'b0;
      sdc_write_q <= 1'b0;
      rd_adr_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifndef SDC_SCHED_PRIO_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      req_len_q   <= req_len_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      sdc_read_q  <= sdc_read_d;
      sdc_write_q <= sdc_write_d;
      rd_adr_q    <= rd_adr_d;
      busy_q      <= busy_d;
`ifndef SDC_SCHED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign sdc_read  = sdc_read_q;
  assign sdc_write = sdc_write_q;
  assign req_len   = req_len_q;
  assign rdAdr     = rd_adr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sdc_port_sched.sv
// tb/tb_sdc_port_sched.sv - scoreboard bench for sdc_port_sched
module tb_sdc_port_sched;

  localparam int TURN_CYC = 2;

  logic       clk = 1'b0;
  logic       rst2 = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [1:0] len0 = 2'd0, len1 = 2'd0;
  logic       sdc_sel = 1'b1;
  logic [1:0] cfg_bl = 2'd0;
  logic [1:0] cas_lat_max = 2'd1;
  logic       gnt0, gnt1, done0, done1, sdc_read, sdc_write, rdAdr, busy;
  logic [1:0] req_len;

  sdc_port_sched #(.TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst2(rst2), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .len0(len0), .len1(len1), .sdc_sel(sdc_sel), .cfg_bl(cfg_bl), .cas_lat_max(cas_lat_max),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .sdc_read(sdc_read),
    .sdc_write(sdc_write), .req_len(req_len), .rdAdr(rdAdr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int port; int we; int n; int b; int nb; int lat; int gnt_cyc; int gap; int len;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int port, int we, int len, int sel, int bl, int cas, int gc, int gap);
    exp_t r;
    int beats;
    beats = (bl == 0) ? 1 : (bl == 1) ? 2 : (bl == 2) ? 4 : 8;
    r.port = port; r.we = we; r.len = len; r.gnt_cyc = gc; r.gap = gap;
    r.b  = sel ? beats : ((beats / 2 < 1) ? 1 : beats / 2);
    r.nb = len + 1;
    r.n  = r.nb * r.b;
    r.lat = we ? r.n + 1 : r.n + 2 + (cas + 1);
    return r;
  endfunction

  // Monitor: follows each transaction from grant to done and pops the scoreboard
  int in_tx = 0, t_port = 0, t_gnt = 0, w_cnt = 0, w_first = 0, ra_cnt = 0, last_done = -1;
  always @(negedge clk) begin
    check("rw_excl", {31'd0, sdc_read & sdc_write}, 0);
    check("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
    if (rst2) begin
      in_tx = 0;
      last_done = -1;
    end else begin
      if (!in_tx && (gnt0 || gnt1)) begin
        if (sb_q.size() == 0) begin
          check("spurious_gnt", {31'd0, gnt0 | gnt1}, 0);
        end else begin
          in_tx = 1; t_port = gnt1 ? 1 : 0; t_gnt = cyc; w_cnt = 0; ra_cnt = 0; w_first = -1;
          check("gnt_port", t_port, sb_q[0].port);
          if (sb_q[0].gnt_cyc >= 0) check("gnt_cyc", cyc, sb_q[0].gnt_cyc);
          if (sb_q[0].gap >= 0 && last_done >= 0) check("req_gap", cyc - last_done, sb_q[0].gap);
        end
      end
      if (in_tx && sb_q.size() > 0) begin
        check("gnt_hold", {31'd0, t_port ? gnt1 : gnt0}, 1);
        if (sdc_read || sdc_write) begin
          if (w_cnt == 0) begin
            w_first = cyc;
            check("dir", {31'd0, sdc_write}, sb_q[0].we);
            check("req_len", {30'd0, req_len}, sb_q[0].len);
          end
          w_cnt++;
        end
        if (rdAdr) begin
          check("rdadr_in_win", {31'd0, sdc_read}, 1);
          check("rdadr_pos", (cyc - w_first) % sb_q[0].b, 0);
          ra_cnt++;
        end
      end
      if (done0 || done1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", {31'd0, done0 | done1}, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_port", {31'd0, done1}, e.port);
          check("done_lat", cyc - t_gnt, e.lat);
          check("win_len", w_cnt, e.n);
          check("win_start", w_first - t_gnt, 1);
          check("rdadr_cnt", ra_cnt, e.we ? 0 : e.nb);
          in_tx = 0;
          last_done = cyc;
        end
      end
    end
  end

  task automatic set_cfg(input int sel, input int bl, input int cas);
    sdc_sel = sel[0]; cfg_bl = bl[1:0]; cas_lat_max = cas[1:0];
  endtask

  // Wait for the scoreboard to empty, then drop both requests in the cycle after done
  task automatic wait_drain(input int bound);
    int k = 0;
    while (sb_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    check("sb_empty", sb_q.size(), 0);
    sb_q.delete();
    #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic single(input int port, input int we, input int len, input int sel, input int bl, input int cas);
    repeat (TURN_CYC + 4) @(posedge clk);
    #1;
    set_cfg(sel, bl, cas);
    if (port == 0) begin we0 = we[0]; len0 = len[1:0]; we1 = ~we[0]; len1 = ~len[1:0]; end
    else           begin we1 = we[0]; len1 = len[1:0]; we0 = ~we[0]; len0 = ~len[1:0]; end
    sb_q.push_back(mk(port, we, len, sel, bl, cas, cyc + 1, -1));
    if (port == 0) req0 = 1'b1; else req1 = 1'b1;
    wait_drain(200);
  endtask

  task automatic rr_burst(input int we, input int p0, input int p1, input int p2);
    int gap;
    repeat (TURN_CYC + 4) @(posedge clk);
    #1;
    set_cfg(1, 0, 1);
    we0 = we[0]; we1 = we[0]; len0 = 2'd0; len1 = 2'd0;
    gap = we ? TURN_CYC + 2 : 2;
    sb_q.push_back(mk(p0, we, 0, 1, 0, 1, cyc + 1, -1));
    sb_q.push_back(mk(p1, we, 0, 1, 0, 1, -1, gap));
    sb_q.push_back(mk(p2, we, 0, 1, 0, 1, -1, gap));
    req0 = 1'b1; req1 = 1'b1;
    wait_drain(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    check("rst_done", {30'd0, done1, done0}, 0);
    check("rst_win", {30'd0, sdc_read, sdc_write}, 0);
    check("rst_rdadr_busy", {30'd0, rdAdr, busy}, 0);
    check("rst_req_len", {30'd0, req_len}, 0);
    @(posedge clk); #1;
    rst2 = 1'b0;

    // SDR single write, 4 beats: then TURN_CYC busy cycles and back to IDLE
    single(0, 1, 0, 1, 2, 1);
    for (int i = 0; i < TURN_CYC; i++) begin
      @(negedge clk);
      check("turn_busy", {31'd0, busy}, 1);
    end
    @(negedge clk);
    check("turn_idle", {31'd0, busy}, 0);

    single(1, 0, 1, 0, 3, 2);   // DDR read, 2 bursts of 8 beats, CAS 3
    single(1, 0, 0, 0, 0, 1);   // DDR single beat, CAS 2
    single(0, 0, 3, 1, 1, 1);   // SDR read, 4 bursts of 2
    single(0, 1, 2, 0, 2, 2);   // DDR write, 3 bursts of 4 beats
    single(1, 0, 2, 0, 1, 2);   // DDR read, bl=2 beats -> 1 cycle bursts

`ifdef SDC_SCHED_PRIO_EN
    rr_burst(1, 0, 0, 0);
    rr_burst(0, 0, 0, 0);
`else
    rr_burst(1, 0, 1, 0);
    rr_burst(0, 1, 0, 1);
`endif

    // Reset at XFER cycle 2 of a DDR read; port 0 wins after release
    repeat (TURN_CYC + 4) @(posedge clk);
    #1;
    set_cfg(0, 3, 2);
    we0 = 1'b0; len0 = 2'd1; we1 = 1'b1; len1 = 2'd0;
    sb_q.push_back(mk(0, 0, 1, 0, 3, 2, cyc + 1, -1));
    req0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst2 = 1'b1; req1 = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst2 = 1'b0;
    sb_q.push_back(mk(0, 0, 1, 0, 3, 2, cyc + 1, -1));
    @(negedge clk);
    check("abort_win", {30'd0, sdc_read, sdc_write}, 0);
    check("abort_gnt", {30'd0, gnt1, gnt0}, 0);
    check("abort_done", {30'd0, done1, done0}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    wait_drain(200);
    repeat (TURN_CYC + 4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
